// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_stream_reader
// Description : Read-side engine for a synchronous FIFO with one-cycle
//               registered read latency. Drains the FIFO into a 3-entry
//               elastic buffer and presents the words on a valid/ready
//               stream at one word per cycle. The FIFO read request is a
//               function of local registers and fifo_empty only, so it never
//               depends combinationally on m_ready.
// Ports       : clk        - clock, rising edge
//               rst        - asynchronous reset, active-low
//               fifo_empty - FIFO empty flag
//               fifo_dout  - FIFO read data, valid the cycle after a read
//               fifo_rd_en - FIFO read request
//               m_data     - stream data (head of buffer)
//               m_valid    - stream data valid
//               m_ready    - downstream ready
//               xfer_cnt   - count of words handed downstream (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  xfer_cnt
);

  // Occupancy encoding of the elastic buffer
  localparam logic [1:0] c_OCC_EMPTY = 2'd0;
  localparam logic [1:0] c_LAST_PTR  = 2'd2;
  localparam logic [2:0] c_DEPTH     = 3'd3;

  logic [DATA_WIDTH-1:0] buf_q [3];
  logic [1:0]            head_q, head_d;
  logic [1:0]            tail_q, tail_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q;
  logic [CNT_WIDTH-1:0]  xfer_cnt_q, xfer_cnt_d;

  logic                  w_pop;
  logic                  w_push;
  logic [2:0]            w_level;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == c_LAST_PTR) ? 2'd0 : p + 2'd1;
  endfunction

  // A word read from the FIFO lands one cycle later, so buffered plus
  // in-flight words must stay within the buffer depth; this guarantees a
  // push never meets a full buffer.
  assign w_level    = {1'b0, occ_q} + {2'b00, inflight_q};
  assign fifo_rd_en = rst && !fifo_empty && (w_level < c_DEPTH);

  assign m_valid  = (occ_q != c_OCC_EMPTY);
  assign m_data   = buf_q[head_q];
  assign xfer_cnt = xfer_cnt_q;

  assign w_pop  = m_valid && m_ready;
  assign w_push = inflight_q;

  always_comb begin
    occ_d      = occ_q + {1'b0, w_push} - {1'b0, w_pop};
    head_d     = w_pop  ? ptr_inc(head_q) : head_q;
    tail_d     = w_push ? ptr_inc(tail_q) : tail_q;
    xfer_cnt_d = xfer_cnt_q + CNT_WIDTH'(w_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        buf_q[i] <= '0;
      end
      head_q     <= 2'd0;
      tail_q     <= 2'd0;
      occ_q      <= c_OCC_EMPTY;
      inflight_q <= 1'b0;
      xfer_cnt_q <= '0;
    end else begin
      // With occ=1 and a simultaneous push+pop, the tail slot equals the new
      // head, so the arriving word becomes the head directly.
      if (w_push) begin
        buf_q[tail_q] <= fifo_dout;
      end
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      inflight_q <= fifo_rd_en;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_stream_reader
// Description : Self-checking bench for fifo_stream_reader. Provides a
//               registered-read FIFO, a word-level scoreboard and an
//               outstanding-count reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

  localparam int DW = 16;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_rd_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [CW-1:0] xfer_cnt;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .xfer_cnt   (xfer_cnt)
  );

  // ---------------- FIFO with one-cycle registered read ----------------
  logic [DW-1:0] mem [1024];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  int            fifo_reads = 0;
  logic          fifo_clr = 1'b0;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_clr) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en && !fifo_empty) begin
      fifo_dout  <= mem[rd_ptr % 1024];
      rd_ptr     <= rd_ptr + 1;
      fifo_reads <= fifo_reads + 1;
    end
  end

  // ---------------- scoreboard / checking ----------------
  logic [DW-1:0] exp_q [$];
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    mem[wr_ptr % 1024] = d;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b0;
    m_ready  = 1'b0;
    fifo_clr = 1'b1;
    exp_q.delete();
    @(negedge clk);
    fifo_clr = 1'b0;
    rst      = 1'b1;
  endtask

  // Reference model: out_cnt = words requested from the FIFO minus words
  // delivered downstream; words requested last cycle are still in flight.
  int   out_cnt   = 0;
  int   dut_out   = 0;
  int   model_cnt = 0;
  logic last_rd   = 1'b0;
  logic m_exp_rd, m_exp_valid;

  always @(negedge clk) begin
    #4;
    if (!rst) begin
      chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
      chk("rst_valid", 64'(m_valid), 64'd0);
      chk("rst_data", 64'(m_data), 64'd0);
      chk("rst_cnt", 64'(xfer_cnt), 64'd0);
      out_cnt   = 0;
      dut_out   = 0;
      model_cnt = 0;
      last_rd   = 1'b0;
    end else begin
      m_exp_rd    = !fifo_empty && (out_cnt < 3);
      m_exp_valid = (out_cnt - (last_rd ? 1 : 0)) > 0;
      chk("rd_en", 64'(fifo_rd_en), 64'(m_exp_rd));
      chk("m_valid", 64'(m_valid), 64'(m_exp_valid));
      chk("xfer_cnt", 64'(xfer_cnt), 64'(model_cnt));
      if (m_exp_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL sb_underflow: got valid with no expected word at %0t", $time);
        end else begin
          chk("m_data", 64'(m_data), 64'(exp_q[0]));
        end
      end
      dut_out = dut_out + (fifo_rd_en ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
      chk("occ_bound", 64'(dut_out <= 3), 64'd1);
      if (m_exp_valid && m_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        model_cnt++;
        out_cnt--;
      end
      if (m_exp_rd) out_cnt++;
      last_rd = m_exp_rd;
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    int nwords;     // words queued before stalling
    int stall;      // cycles with m_ready low
    int exp_reads;  // FIFO reads issued during the stall
  } row_t;

  row_t rows [6];
  int   r0_reads, got, first_c, last_c, written;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rows[0] = '{nwords: 8, stall: 6, exp_reads: 3};
    rows[1] = '{nwords: 2, stall: 6, exp_reads: 2};
    rows[2] = '{nwords: 1, stall: 4, exp_reads: 1};
    rows[3] = '{nwords: 5, stall: 2, exp_reads: 2};
    rows[4] = '{nwords: 3, stall: 3, exp_reads: 3};
    rows[5] = '{nwords: 8, stall: 0, exp_reads: 0};

    // Reset held with words waiting in the FIFO
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) write_word(16'h7000 + 16'(i));
    repeat (2) @(negedge clk);
    #1;
    chk("t1_rd_en", 64'(fifo_rd_en), 64'd0);
    chk("t1_valid", 64'(m_valid), 64'd0);
    chk("t1_data", 64'(m_data), 64'd0);
    chk("t1_cnt", 64'(xfer_cnt), 64'd0);

    // Single word latency: rd_en in t, m_valid in t+2
    do_reset();
    m_ready = 1'b1;
    write_word(16'hA5A5);
    #1;
    chk("t2_rd_en_t", 64'(fifo_rd_en), 64'd1);
    @(negedge clk); #4;
    chk("t2_valid_t1", 64'(m_valid), 64'd0);
    @(negedge clk); #4;
    chk("t2_valid_t2", 64'(m_valid), 64'd1);
    chk("t2_data_t2", 64'(m_data), 64'hA5A5);
    @(negedge clk); #4;
    chk("t2_valid_t3", 64'(m_valid), 64'd0);
    chk("t2_cnt", 64'(xfer_cnt), 64'd1);

    // Table: stall then drain at full rate
    for (int r = 0; r < 6; r++) begin
      do_reset();
      r0_reads = fifo_reads;
      for (int i = 0; i < rows[r].nwords; i++) write_word(16'((r << 8) + i + 1));
      repeat (rows[r].stall) @(negedge clk);
      chk("row_reads", 64'(fifo_reads - r0_reads), 64'(rows[r].exp_reads));
      m_ready = 1'b1;
      got = 0; first_c = -1; last_c = -1;
      for (int c = 0; c < 100 && got < rows[r].nwords; c++) begin
        #4;
        if (m_valid) begin
          if (first_c < 0) first_c = c;
          last_c = c;
          got++;
        end
        @(negedge clk);
      end
      chk("row_got", 64'(got), 64'(rows[r].nwords));
      chk("row_span", 64'(last_c - first_c + 1), 64'(rows[r].nwords));
      #4;
      chk("row_cnt", 64'(xfer_cnt), 64'(rows[r].nwords));
    end

    // Random ready with concurrent writes
    do_reset();
    written = 0;
    for (int c = 0; c < 3000 && model_cnt < 64; c++) begin
      @(negedge clk);
      if (written < 64 && $urandom_range(0, 1) == 1) begin
        write_word(16'h1000 + 16'(written));
        written++;
      end
      m_ready = ($urandom_range(0, 99) < 60);
    end
    @(negedge clk); #4;
    chk("rand_cnt", 64'(xfer_cnt), 64'd64);
    chk("rand_left", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a burst (occ=2, inflight=1)
    do_reset();
    for (int i = 0; i < 8; i++) write_word(16'h3000 + 16'(i));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_rd_en", 64'(fifo_rd_en), 64'd0);
    chk("t6_valid", 64'(m_valid), 64'd0);
    chk("t6_data", 64'(m_data), 64'd0);
    chk("t6_cnt", 64'(xfer_cnt), 64'd0);
    fifo_clr = 1'b1;
    exp_q.delete();
    @(negedge clk);
    fifo_clr = 1'b0;
    rst      = 1'b1;
    m_ready  = 1'b1;
    repeat (5) begin
      @(negedge clk); #4;
      chk("t6_idle", 64'(m_valid), 64'd0);
    end
    @(negedge clk);
    write_word(16'h0BEE);
    @(negedge clk);
    @(negedge clk); #4;
    chk("t6_new_valid", 64'(m_valid), 64'd1);
    chk("t6_new_data", 64'(m_data), 64'h0BEE);
    @(negedge clk); #4;
    chk("t6_new_cnt", 64'(xfer_cnt), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
